// File: rtl/intpol2_d4_sample_window_if.sv
// Sample-window bus: upstream valid/ready sample input plus the
// windowed tap/phase outputs toward the downstream subtract stage.
//   master : drives in_valid/in_data/out_ready, observes window outputs
//   slave  : the sample-window block itself
interface intpol2_d4_sample_window_if #(
    parameter int unsigned DATAPATH_WIDTH = 32,
    parameter int unsigned N_bits         = 2,
    parameter int unsigned PHASE_LOG2     = 2
);
    localparam int unsigned OUT_W = DATAPATH_WIDTH + N_bits;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATAPATH_WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          y0;
    logic [OUT_W-1:0]          y1;
    logic [OUT_W-1:0]          y2;
    logic [PHASE_LOG2-1:0]     phase;
    logic                      out_first;
    logic                      sub_en;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, y0, y1, y2, phase, out_first, sub_en
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, y0, y1, y2, phase, out_first, sub_en
    );
endinterface

// File: rtl/intpol2_d4_sample_window.sv
// Interpolator sample window: keeps a 3-tap sliding window of signed input
// samples (y0 newest .. y2 oldest), sign-extends them by N_bits and replays
// the window for 2^PHASE_LOG2 output phases per accepted sample.
// Ports:
//   clk   - clock, rising edge
//   rstn  - synchronous active-low reset
//   flush - soft reset to FILL (only when INTPOL2_D4_FLUSH_EN is defined)
//   bus   - slave side of intpol2_d4_sample_window_if (handshakes, taps,
//           phase, out_first, sub_en)
// Optional macro: INTPOL2_D4_FLUSH_EN adds the flush input.
module intpol2_d4_sample_window #(
    parameter int unsigned DATAPATH_WIDTH = 32,
    parameter int unsigned N_bits         = 2,
    parameter int unsigned PHASE_LOG2     = 2
) (
    input  logic clk,
    input  logic rstn,
`ifdef INTPOL2_D4_FLUSH_EN
    input  logic flush,
`endif
    intpol2_d4_sample_window_if.slave bus
);
    localparam int unsigned OUT_W = DATAPATH_WIDTH + N_bits;
    localparam logic [PHASE_LOG2-1:0] PHASE_LAST = '1;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            fill_cnt_q, fill_cnt_d;
    logic [OUT_W-1:0]      y0_q, y0_d;
    logic [OUT_W-1:0]      y1_q, y1_d;
    logic [OUT_W-1:0]      y2_q, y2_d;
    logic [PHASE_LOG2-1:0] phase_q, phase_d;

    logic                  in_ready_c;
    logic                  out_valid_c;
    logic                  accept_c;
    logic [OUT_W-1:0]      sext_c;

    // Handshake outputs depend only on registered state and out_ready
    assign in_ready_c  = (state_q == ST_FILL) || (state_q == ST_WAIT);
    assign out_valid_c = (state_q == ST_RUN);
    assign accept_c    = bus.in_valid && in_ready_c;
    assign sext_c      = OUT_W'($signed(bus.in_data));

    // Next-state, window shift and phase sequencing
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        phase_d    = phase_q;

        if (accept_c) begin
            y2_d = y1_q;
            y1_d = y0_q;
            y0_d = sext_c;
        end

        unique case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    if (fill_cnt_q == 2'd2) begin
                        fill_cnt_d = 2'd0;
                        phase_d    = '0;
                        state_d    = ST_RUN;
                    end else begin
                        fill_cnt_d = 2'(fill_cnt_q + 2'd1);
                    end
                end
            end
            ST_RUN: begin
                if (bus.out_ready) begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        phase_d = PHASE_LOG2'(phase_q + 1'b1);
                    end
                end
            end
            ST_WAIT: begin
                if (accept_c) begin
                    phase_d = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

`ifdef INTPOL2_D4_FLUSH_EN
        // Soft reset overrides any accept or phase handshake this cycle
        if (flush) begin
            state_d    = ST_FILL;
            fill_cnt_d = 2'd0;
            y0_d       = '0;
            y1_d       = '0;
            y2_d       = '0;
            phase_d    = '0;
        end
`endif
    end

    // State and window registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= 2'd0;
            y0_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.y2        = y2_q;
    assign bus.phase     = phase_q;
    assign bus.out_first = out_valid_c && (phase_q == '0);
    assign bus.sub_en    = out_valid_c && bus.out_ready;
endmodule

// File: tb/tb_intpol2_d4_sample_window.sv
// Directed testbench for intpol2_d4_sample_window: fill, phase replay,
// stalls, window slide, bubble, mid-run reset, sign extension and
// (when INTPOL2_D4_FLUSH_EN is defined) flush.
module tb_intpol2_d4_sample_window;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 2;
    localparam int unsigned PL = 2;

    logic clk;
    logic rstn;
`ifdef INTPOL2_D4_FLUSH_EN
    logic flush;
`endif

    int n_checks;
    int n_fail;

    intpol2_d4_sample_window_if #(
        .DATAPATH_WIDTH(DW), .N_bits(NB), .PHASE_LOG2(PL)
    ) bus ();

    intpol2_d4_sample_window #(
        .DATAPATH_WIDTH(DW), .N_bits(NB), .PHASE_LOG2(PL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
`ifdef INTPOL2_D4_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_win(input string tag, input logic [63:0] e0,
                             input logic [63:0] e1, input logic [63:0] e2);
        check_eq({tag, "_y0"}, 64'(bus.y0), e0);
        check_eq({tag, "_y1"}, 64'(bus.y1), e1);
        check_eq({tag, "_y2"}, 64'(bus.y2), e2);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef INTPOL2_D4_FLUSH_EN
        flush         = 1'b0;
`endif
        step();
        step();

        // Reset state
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_phase", 64'(bus.phase), 64'd0);
        check_eq("rst_sub_en", 64'(bus.sub_en), 64'd0);
        check_win("rst", 64'd0, 64'd0, 64'd0);

        // Fill with 10, -5, 7
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd10;
        step();
        bus.in_data   = 32'hFFFF_FFFB;
        step();
        check_eq("fill2_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fill2_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_data   = 32'd7;
        step();
        bus.in_valid  = 1'b0;
        check_eq("run_out_valid", 64'(bus.out_valid), 64'd1);
        check_eq("run_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("run_phase0", 64'(bus.phase), 64'd0);
        check_eq("run_first0", 64'(bus.out_first), 64'd1);
        check_eq("run_sub_en0", 64'(bus.sub_en), 64'd1);
        check_win("run", 64'd7, 64'h3_FFFF_FFFB, 64'd10);

        for (int p = 1; p < 4; p++) begin
            step();
            check_eq("run_phase", 64'(bus.phase), 64'(p));
            check_eq("run_first", 64'(bus.out_first), 64'd0);
            check_eq("run_sub_en", 64'(bus.sub_en), 64'd1);
        end

        // Last handshake -> WAIT, taps held
        step();
        check_eq("wait_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("wait_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("wait_sub_en", 64'(bus.sub_en), 64'd0);
        check_win("wait", 64'd7, 64'h3_FFFF_FFFB, 64'd10);
        step();
        step();
        check_eq("wait_hold_valid", 64'(bus.out_valid), 64'd0);
        check_win("wait_hold", 64'd7, 64'h3_FFFF_FFFB, 64'd10);

        // Slide in 20 from WAIT
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd20;
        step();
        check_eq("slide_out_valid", 64'(bus.out_valid), 64'd1);
        check_eq("slide_phase", 64'(bus.phase), 64'd0);
        check_win("slide", 64'd20, 64'd7, 64'h3_FFFF_FFFB);

        // Stall pattern 1,0,0,1 with a held in_valid that must be ignored
        bus.in_data = 32'd99;
        begin
            logic [3:0] rdy_pat;
            logic [1:0] exp_ph;
            rdy_pat = 4'b1001;
            exp_ph  = 2'd0;
            for (int i = 0; i < 4; i++) begin
                bus.out_ready = rdy_pat[3-i];
                #1;
                check_eq("stall_sub_en", 64'(bus.sub_en), 64'(rdy_pat[3-i]));
                step();
                if (rdy_pat[3-i]) exp_ph = 2'(exp_ph + 2'd1);
                check_eq("stall_phase", 64'(bus.phase), 64'(exp_ph));
                check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
                check_win("stall", 64'd20, 64'd7, 64'h3_FFFF_FFFB);
            end
        end

        // Phase 2 -> 3 -> WAIT bubble -> next window
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_eq("bub_phase3", 64'(bus.phase), 64'd3);
        step();
        check_eq("bub_gap_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd30;
        step();
        bus.in_valid = 1'b0;
        check_eq("bub_next_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bub_next_first", 64'(bus.out_first), 64'd1);
        check_win("bub_next", 64'd30, 64'd20, 64'd7);

        // Reset mid-run at phase 2
        step();
        step();
        check_eq("mid_phase2", 64'(bus.phase), 64'd2);
        rstn = 1'b0;
        step();
        check_eq("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("mrst_phase", 64'(bus.phase), 64'd0);
        check_win("mrst", 64'd0, 64'd0, 64'd0);

        // Refill; third sample checks sign extension of the MSB
        rstn         = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd1;
        step();
        bus.in_data  = 32'd2;
        step();
        check_eq("refill2_valid", 64'(bus.out_valid), 64'd0);
        bus.in_data  = 32'h8000_0000;
        step();
        bus.in_valid = 1'b0;
        check_eq("refill_valid", 64'(bus.out_valid), 64'd1);
        check_win("sext", 64'h3_8000_0000, 64'd2, 64'd1);

`ifdef INTPOL2_D4_FLUSH_EN
        // Run out to WAIT, then flush together with an offered sample
        for (int i = 0; i < 4; i++) step();
        check_eq("fl_wait_valid", 64'(bus.out_valid), 64'd0);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd5;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(bus.in_ready), 64'd1);
        check_win("fl", 64'd0, 64'd0, 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd4;
        step();
        step();
        check_eq("fl_fill2_valid", 64'(bus.out_valid), 64'd0);
        step();
        bus.in_valid = 1'b0;
        check_eq("fl_fill3_valid", 64'(bus.out_valid), 64'd1);
        check_win("fl_fill", 64'd4, 64'd4, 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Watchdog so a broken DUT can never hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end
endmodule
